// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue scoreboard with pending-write counters, drain FSM and stall statistics
//
// Tracks up to three instructions in stages 1-3. Each register 1..31 has a
// small counter of the writes still in flight to it. The counter lets a later
// instruction that reads the register hold in decode until the writes retire.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   issue_valid / issue_ready  decode-stage instruction handshake into stage 1
//   issue_rs1/rs2/rd           source and destination register numbers
//   issue_check_rs1/rs2        source operand is actually read
//   issue_reg_we               instruction writes issue_rd
//   retire_valid/rd/we         one instruction leaves stage 3
//   flush                      discard all in-flight work
//   drain_req                  level request to empty the pipeline
//   drain_done                 pipeline drained, held while drain_req stays high
//   stall                      decode has an instruction but it cannot enter
//   inflight                   instructions currently in stages 1-3
//   stall_cycles               saturating count of stalled cycles
//   error                      sticky retire-protocol violation

module issue_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_check_rs1,
    input  logic        issue_check_rs2,
    input  logic        issue_reg_we,
    input  logic        retire_valid,
    input  logic [4:0]  retire_rd,
    input  logic        retire_we,
    input  logic        flush,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        stall,
    output logic [1:0]  inflight,
    output logic [15:0] stall_cycles,
    output logic        error
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Entry 0 exists only so that a 5-bit index is always in range; it is
    // held at zero so r0 can never look pending.
    logic [1:0]  pend [32];

    logic        hazard;
    logic        fire;
    logic        inc_en;
    logic        dec_req;
    logic        dec_en;
    logic        retire_bad;
    logic        retire_ok;
    logic [1:0]  inflight_nxt;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    // Hazard looks only at registered counters: a retire in this cycle does
    // not release a dependent instruction until the following cycle.
    always_comb begin
        hazard = 1'b0;
        if (issue_check_rs1 && (issue_rs1 != 5'd0) && (pend[issue_rs1] != 2'd0))
            hazard = 1'b1;
        if (issue_check_rs2 && (issue_rs2 != 5'd0) && (pend[issue_rs2] != 2'd0))
            hazard = 1'b1;
    end

    // inflight==3 blocks issue even when a retire frees a slot this cycle.
    assign issue_ready = (state == RUN) && !flush && !hazard && (inflight != 2'd3);
    assign fire        = issue_valid && issue_ready;
    assign stall       = issue_valid && !issue_ready;
    assign drain_done  = (state == DONE);

    assign inc_en  = fire && issue_reg_we && (issue_rd != 5'd0);
    assign dec_req = retire_valid && retire_we && (retire_rd != 5'd0);

    // An illegal retire (nothing in flight, or releasing a register with no
    // pending write) is dropped entirely and only raises the sticky error.
    assign retire_bad = retire_valid &&
                        ((inflight == 2'd0) || (dec_req && (pend[retire_rd] == 2'd0)));
    assign retire_ok  = retire_valid && !retire_bad;
    assign dec_en     = dec_req && !retire_bad;

    assign inc_vec = inc_en ? (32'd1 << issue_rd)  : 32'd0;
    assign dec_vec = dec_en ? (32'd1 << retire_rd) : 32'd0;

    always_comb begin
        inflight_nxt = inflight;
        if (flush)
            inflight_nxt = 2'd0;
        else
            inflight_nxt = inflight + {1'b0, fire} - {1'b0, retire_ok};
    end

    // Drain sequencing. DRAIN always lasts at least one cycle, so a request
    // with an empty pipeline still passes through DRAIN before DONE. Dropping
    // the request wins over completing the drain.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (drain_req)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)
                    state_nxt = RUN;
                else if (inflight_nxt == 2'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!drain_req)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            inflight     <= 2'd0;
            stall_cycles <= 16'd0;
            error        <= 1'b0;
            for (int r = 0; r < 32; r++)
                pend[r] <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;

            if (stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;

            // A flush cycle performs no protocol check on the retire it discards.
            if (!flush && retire_bad)
                error <= 1'b1;

            pend[0] <= 2'd0;
            for (int r = 1; r < 32; r++) begin
                if (flush)
                    pend[r] <= 2'd0;
                else if (inc_vec[r] && !dec_vec[r] && (pend[r] != 2'd3))
                    pend[r] <= pend[r] + 2'd1;
                else if (dec_vec[r] && !inc_vec[r])
                    pend[r] <= pend[r] - 2'd1;
            end
        end
    end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (synchronous, active-high reset).
REQ-002 The block SHALL provide the issue-side ports: issue_valid input 1 (decode-stage instruction present), issue_ready output 1 (instruction may enter stage 1), issue_rs1 input 5, issue_rs2 input 5, issue_rd input 5, issue_check_rs1 input 1, issue_check_rs2 input 1, issue_reg_we input 1.
REQ-003 The block SHALL provide the retire-side ports: retire_valid input 1 (one instruction leaves stage 3), retire_rd input 5, retire_we input 1 (retiring instruction writes rd).
REQ-004 The block SHALL provide the control ports: flush input 1 (discard all in-flight work), drain_req input 1 (level request to empty the pipeline).
REQ-005 The block SHALL provide the status ports: drain_done output 1, stall output 1, inflight output 2 (instructions in stages 1-3), stall_cycles output 16, error output 1 (sticky).

Function
REQ-006 The block SHALL keep a 2-bit pending-write counter per register 1..31; register 0 SHALL never be pending.
REQ-007 The block SHALL compute hazard = (issue_check_rs1 & rs1!=0 & pend[rs1]!=0) | (issue_check_rs2 & rs2!=0 & pend[rs2]!=0), using registered state only, with no same-cycle bypass from retire.
REQ-008 The block SHALL drive issue_ready = (state==RUN) & !flush & !hazard & (inflight<3), combinationally, independent of issue_valid.
REQ-009 The block SHALL define fire = issue_valid & issue_ready and stall = issue_valid & !issue_ready.
REQ-010 On fire with issue_reg_we=1 and issue_rd!=0, the block SHALL increment pend[issue_rd] at the next edge.
REQ-011 On retire_valid with retire_we=1 and retire_rd!=0, the block SHALL decrement pend[retire_rd] at the next edge.
REQ-012 When an increment and a decrement target the same register in the same cycle, that register's counter SHALL be unchanged.
REQ-013 The block SHALL update inflight as inflight + fire - retire_valid; a simultaneous fire and retire SHALL leave it unchanged.
REQ-014 At inflight==3, issue_ready SHALL be 0 even if a retire occurs that cycle.
REQ-015 Retire_valid with inflight==0, or a decrement of a zero counter, SHALL leave the state unchanged and set error=1 until reset.
REQ-016 The block SHALL increment stall_cycles on each cycle with stall=1 and saturate it at 0xFFFF.
REQ-017 Flush SHALL take priority over issue/retire: at the next edge all pend counters and inflight SHALL clear, with no error check in that cycle.
REQ-018 While flush=1, issue_ready SHALL be 0 and the state SHALL be unaffected except as drain rules below.
REQ-019 The block SHALL implement FSM states RUN, DRAIN, DONE.
REQ-020 FSM transition RUN->DRAIN: when drain_req=1. While in DRAIN, issue_ready SHALL be 0 and retires SHALL proceed.
REQ-021 FSM transition DRAIN->DONE: at the first edge where inflight==0 (after update, or when flush occurs).
REQ-022 FSM transition DONE->RUN: when drain_req=0.
REQ-023 FSM transition DRAIN->RUN: when drain_req drops before inflight reaches 0.
REQ-024 The block SHALL drive drain_done=1 exactly while in state DONE.
REQ-025 With drain_req=1 and inflight==0 in RUN, the block SHALL pass through DRAIN for one cycle, then enter DONE.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set state=RUN, all pend=0, inflight=0, stall_cycles=0, error=0, drain_done=0.
REQ-027 Rst SHALL take priority over flush, drain_req, issue and retire.
REQ-028 Rst asserted mid-drain or with instructions in flight SHALL discard them without setting error.
REQ-029 After reset, issue_ready SHALL be 1 in the first cycle (absent flush).
REQ-030 After reset, stall SHALL equal 0 unless issue_valid=1 and issue_ready=0.

Verification
REQ-031 The bench SHALL cover: issue rd=5 we=1, then issue rs1=5 check_rs1=1 -> stall=1, issue_ready=0 until retire rd=5, then ready in the cycle after the retire; stall_cycles counts the stalled cycles.
REQ-032 The bench SHALL cover: three back-to-back non-dependent issues -> inflight=3, fourth held off; a retire and a 4th issue in the same cycle -> the 4th is not accepted that cycle.
REQ-033 The bench SHALL cover: issue rd=0 we=1, then rs1=0 check -> no stall; issue rd=7 twice, retire once -> pend[7]=1 and a dependent instruction still stalls.
REQ-034 The bench SHALL cover: flush with inflight=2 and pend[3]=2 -> next cycle inflight=0, no stall on r3, error=0.
REQ-035 The bench SHALL cover: drain_req with inflight=2 -> issue_ready=0, drain_done=1 the cycle after the last retire; drain_req low -> RUN, issue_ready=1.
REQ-036 The bench SHALL cover: retire_valid at inflight=0 -> error=1, held through subsequent traffic, cleared only by rst.
